// File: rtl/brisc_store_buffer.sv
// In-order store buffer between MEM and the data cache: committed SW/SB stores
// are queued, retired in program order over valid/ready, and forwarded to loads.
module brisc_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     push_is_byte,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [ADDR_W-1:0]        drain_addr,
  output logic [DATA_W-1:0]        drain_data,
  output logic [DATA_W/8-1:0]      drain_be,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic                     ld_valid,
  input  logic                     ld_is_byte,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_stall,
  output logic                     empty
);

  localparam int BYTE_LEN = 8;
  localparam int BE_W     = DATA_W / BYTE_LEN;
  localparam int OFF_W    = $clog2(BE_W);
  localparam int WA_W     = ADDR_W - OFF_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic [WA_W-1:0]   waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push_fire;
  logic              drain_fire;
  logic [DATA_W-1:0] push_wdata;
  logic [BE_W-1:0]   push_be;
  logic [OFF_W-1:0]  push_lane;
  logic [OFF_W-1:0]  ld_lane;
  logic [WA_W-1:0]   ld_waddr;
  logic              match_found;
  logic [PTR_W-1:0]  match_idx;
  logic              match_covers;

  // Ready depends only on the registered count: a full buffer refuses a push
  // even when the head drains in the same cycle.
  assign push_ready  = (count_q != CNT_W'(DEPTH));
  assign drain_valid = (count_q != '0);
  assign empty       = (count_q == '0);
  assign push_fire   = push_valid && push_ready;
  assign drain_fire  = drain_valid && drain_ready;

  assign push_lane   = push_addr[OFF_W-1:0];
  assign ld_lane     = ld_addr[OFF_W-1:0];
  assign ld_waddr    = ld_addr[ADDR_W-1:OFF_W];

  always_comb begin
    push_wdata = push_data;
    push_be    = '1;
    if (push_is_byte) begin
      push_wdata = {BE_W{push_data[BYTE_LEN-1:0]}};
      push_be    = BE_W'(1) << push_lane;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(drain_fire);
    tail_d  = tail_q + PTR_W'(push_fire);
    count_d = count_q;
    case ({push_fire, drain_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking ones
  // here would let readers in the same edge see half-updated pointers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; validity comes only from
  // count_q, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      waddr_q[tail_q] <= push_addr[ADDR_W-1:OFF_W];
      data_q[tail_q]  <= push_wdata;
      be_q[tail_q]    <= push_be;
    end
  end

  assign drain_addr = {waddr_q[head_q], {OFF_W{1'b0}}};
  assign drain_data = data_q[head_q];
  assign drain_be   = be_q[head_q];

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (waddr_q[head_q + PTR_W'(i)] == ld_waddr)) begin
        match_found = 1'b1;
        match_idx   = head_q + PTR_W'(i);
      end
    end
  end

  assign match_covers = ld_is_byte ? be_q[match_idx][ld_lane] : (&be_q[match_idx]);

  always_comb begin
    ld_hit   = ld_valid && match_found && match_covers;
    ld_stall = ld_valid && match_found && !match_covers;
    ld_data  = '0;
    if (ld_hit) begin
      if (ld_is_byte) begin
        ld_data = DATA_W'(data_q[match_idx][ld_lane*BYTE_LEN +: BYTE_LEN]);
      end else begin
        ld_data = data_q[match_idx];
      end
    end
  end

endmodule

// File: tb/tb_brisc_store_buffer.sv
// Self-checking bench for brisc_store_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_brisc_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic        push_is_byte;
  logic        drain_valid;
  logic        drain_ready;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_be;
  logic [31:0] ld_addr;
  logic        ld_valid;
  logic        ld_is_byte;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        empty;

  int checks = 0;
  int errors = 0;

  brisc_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .push_is_byte(push_is_byte),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_addr  (drain_addr),
    .drain_data  (drain_data),
    .drain_be    (drain_be),
    .ld_addr     (ld_addr),
    .ld_valid    (ld_valid),
    .ld_is_byte  (ld_is_byte),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // Reference model: the pending stores in program order.
  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  // Applies this cycle's handshakes to the model, then advances past the edge.
  task automatic tick();
    ent_t e;
    if (!reset_n) begin
      q.delete();
    end else begin
      bit do_push  = push_valid && (q.size() < DEPTH);
      bit do_drain = drain_ready && (q.size() > 0);
      if (do_drain) void'(q.pop_front());
      if (do_push) begin
        e.waddr = push_addr[31:2];
        if (push_is_byte) begin
          e.data = {4{push_data[7:0]}};
          e.be   = 4'b0001 << push_addr[1:0];
        end else begin
          e.data = push_data;
          e.be   = 4'hF;
        end
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void model_ld(input logic [31:0] a, input bit isb,
                                   output bit hit, output bit stall,
                                   output logic [31:0] d);
    hit = 1'b0; stall = 1'b0; d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].waddr == a[31:2]) begin
        if (isb ? q[i].be[a[1:0]] : (q[i].be == 4'hF)) begin
          hit = 1'b1;
          d   = isb ? {24'h0, q[i].data[8*a[1:0] +: 8]} : q[i].data;
        end else begin
          stall = 1'b1;
        end
        break;
      end
    end
  endfunction

  task automatic drive_push(input bit v, input logic [31:0] a, input logic [31:0] d, input bit isb);
    push_valid = v; push_addr = a; push_data = d; push_is_byte = isb;
  endtask

  task automatic drive_ld(input bit v, input logic [31:0] a, input bit isb);
    ld_valid = v; ld_addr = a; ld_is_byte = isb;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    drain_ready = 1'b0;
    drive_ld(1'b1, 32'h100, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b exp 1", push_ready); end
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL reset_drain_valid: got %b exp 0", drain_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit: got %b exp 0", ld_hit); end
    checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL reset_ld_stall: got %b exp 0", ld_stall); end
  endtask

  task automatic test_sw_drain();
    drain_ready = 1'b0;
    drive_push(1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
    drive_ld(1'b1, 32'h100, 1'b0);
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL sw_same_cycle_fwd: got %b exp 0", ld_hit); end
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL sw_same_cycle_drain: got %b exp 0", drain_valid); end
    tick();
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (drain_valid !== 1'b1) begin errors++; $display("FAIL sw_drain_valid[%0d]: got %b exp 1", c, drain_valid); end
      checks++; if (drain_addr !== 32'h100) begin errors++; $display("FAIL sw_drain_addr[%0d]: got %h exp 00000100", c, drain_addr); end
      checks++; if (drain_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_drain_data[%0d]: got %h exp deadbeef", c, drain_data); end
      checks++; if (drain_be !== 4'hF) begin errors++; $display("FAIL sw_drain_be[%0d]: got %h exp f", c, drain_be); end
      if (c == 0) begin
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_fwd_next_cycle: hit %b data %h exp 1 deadbeef", ld_hit, ld_data); end
      end
      tick();
    end
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sw_empty_after_drain: got %b exp 1", empty); end
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL sw_valid_after_drain: got %b exp 0", drain_valid); end
  endtask

  task automatic test_sb();
    drive_push(1'b1, 32'h203, 32'h123456A5, 1'b1);
    tick();
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    drive_ld(1'b1, 32'h203, 1'b1);
    #1;
    checks++; if (drain_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b exp 1000", drain_be); end
    checks++; if (drain_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_data: got %h exp a5a5a5a5", drain_data); end
    checks++; if (drain_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h exp 00000200", drain_addr); end
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h000000A5) begin errors++; $display("FAIL sb_lb_fwd: hit %b data %h exp 1 000000a5", ld_hit, ld_data); end
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
  endtask

  task automatic test_fill_wrap();
    drain_ready = 1'b0;
    drive_ld(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_push(1'b1, 32'h600 + 4*k, 32'hC0DE0000 + k, 1'b0);
      #1;
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b exp 1", k, push_ready); end
      tick();
    end
    drive_push(1'b1, 32'h610, 32'hC0DE0004, 1'b0);
    drain_ready = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready_with_drain: got %b exp 0", push_ready); end
    checks++; if (drain_data !== 32'hC0DE0000) begin errors++; $display("FAIL full_head: got %h exp c0de0000", drain_data); end
    tick();
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL count3_ready: got %b exp 1", push_ready); end
    checks++; if (drain_data !== 32'hC0DE0001) begin errors++; $display("FAIL count3_head: got %h exp c0de0001", drain_data); end
    tick();
    for (int k = 5; k < 8; k++) begin
      drive_push(1'b1, 32'h600 + 4*k, 32'hC0DE0000 + k, 1'b0);
      #1;
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL pushdrain_ready[%0d]: got %b exp 1", k, push_ready); end
      checks++; if (drain_data !== 32'hC0DE0000 + k - 3) begin errors++; $display("FAIL pushdrain_head[%0d]: got %h exp %h", k, drain_data, 32'hC0DE0000 + k - 3); end
      tick();
    end
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 5; k < 8; k++) begin
      #1;
      checks++; if (drain_data !== 32'hC0DE0000 + k || drain_addr !== 32'h600 + 4*k) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h@%h exp %h@%h", k, drain_data, drain_addr, 32'hC0DE0000 + k, 32'h600 + 4*k);
      end
      tick();
    end
    drain_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b exp 1", empty); end
  endtask

  task automatic test_forward();
    drain_ready = 1'b0;
    drive_push(1'b1, 32'h300, 32'h11111111, 1'b0); tick();
    drive_push(1'b1, 32'h300, 32'h22222222, 1'b0); tick();
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    drive_ld(1'b1, 32'h300, 1'b0);
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'h22222222) begin
      errors++; $display("FAIL fwd_lw_youngest: hit %b stall %b data %h exp 1 0 22222222", ld_hit, ld_stall, ld_data);
    end
    drive_ld(1'b1, 32'h302, 1'b1);
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h00000022) begin errors++; $display("FAIL fwd_lb: hit %b data %h exp 1 00000022", ld_hit, ld_data); end
    drive_ld(1'b1, 32'h300, 1'b0);
    drain_ready = 1'b1;
    tick();
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22222222) begin errors++; $display("FAIL fwd_while_draining: hit %b data %h exp 1 22222222", ld_hit, ld_data); end
    tick();
    drain_ready = 1'b0;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_after_retire: got %b exp 0", ld_hit); end
  endtask

  task automatic test_partial();
    drain_ready = 1'b0;
    drive_push(1'b1, 32'h400, 32'h12345678, 1'b0); tick();
    drive_push(1'b1, 32'h401, 32'h000000FF, 1'b1); tick();
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    drive_ld(1'b1, 32'h400, 1'b0); #1;
    checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL partial_lw: stall %b hit %b exp 1 0", ld_stall, ld_hit); end
    drive_ld(1'b1, 32'h401, 1'b1); #1;
    checks++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'h000000FF) begin
      errors++; $display("FAIL partial_lb_hit: hit %b stall %b data %h exp 1 0 000000ff", ld_hit, ld_stall, ld_data);
    end
    drive_ld(1'b1, 32'h402, 1'b1); #1;
    checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL partial_lb_402: stall %b hit %b exp 1 0", ld_stall, ld_hit); end
    drive_ld(1'b1, 32'h400, 1'b1); #1;
    checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL partial_no_merge: stall %b hit %b exp 1 0", ld_stall, ld_hit); end
    drive_ld(1'b0, 32'h401, 1'b1); #1;
    checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0) begin
      errors++; $display("FAIL ld_invalid: hit %b stall %b data %h exp 0 0 0", ld_hit, ld_stall, ld_data);
    end
    drain_ready = 1'b1;
    tick(); tick();
    drain_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_push(1'b1, 32'h700 + 4*k, 32'hBEEF0000 + k, 1'b0);
      tick();
    end
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    drain_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drain_ready = 1'b0;
    drive_ld(1'b1, 32'h700, 1'b0);
    #1;
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drain_valid: got %b exp 0", drain_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b exp 1", empty); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rstmid_push_ready: got %b exp 1", push_ready); end
    checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0) begin errors++; $display("FAIL rstmid_lookup: hit %b stall %b exp 0 0", ld_hit, ld_stall); end
  endtask

  task automatic test_random();
    bit          e_hit, e_stall;
    logic [31:0] e_data;
    logic [31:0] a;
    bit          isb;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      isb = bit'($urandom_range(0, 1));
      a   = 32'h500 + 4*$urandom_range(0, 3) + (isb ? $urandom_range(0, 3) : 0);
      drive_push(bit'($urandom_range(0, 1)), a, $urandom, isb);
      if ((i / 200) % 2 == 0) drain_ready = ($urandom_range(0, 3) == 0);
      else                    drain_ready = ($urandom_range(0, 3) != 0);
      isb = bit'($urandom_range(0, 1));
      drive_ld($urandom_range(0, 3) != 0, 32'h500 + 4*$urandom_range(0, 4) + $urandom_range(0, 3), isb);
      #1;
      if (ld_valid) model_ld(ld_addr, ld_is_byte, e_hit, e_stall, e_data);
      else begin e_hit = 1'b0; e_stall = 1'b0; e_data = '0; end
      checks++; if (push_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_push_ready @%0d: got %b exp %b", i, push_ready, q.size() < DEPTH); end
      checks++; if (drain_valid !== (q.size() != 0) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rnd_valid_empty @%0d: got %b %b for %0d entries", i, drain_valid, empty, q.size());
      end
      if (q.size() != 0) begin
        checks++; if (drain_addr !== {q[0].waddr, 2'b00} || drain_data !== q[0].data || drain_be !== q[0].be) begin
          errors++; $display("FAIL rnd_head @%0d: got %h/%h/%h exp %h/%h/%h", i, drain_addr, drain_data, drain_be, {q[0].waddr, 2'b00}, q[0].data, q[0].be);
        end
      end
      checks++; if (ld_hit !== e_hit || ld_stall !== e_stall) begin
        errors++; $display("FAIL rnd_lookup @%0d: hit %b stall %b exp %b %b", i, ld_hit, ld_stall, e_hit, e_stall);
      end
      if (e_hit || !ld_valid) begin
        checks++; if (ld_data !== e_data) begin errors++; $display("FAIL rnd_ld_data @%0d: got %h exp %h", i, ld_data, e_data); end
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_push(1'b0, 32'h0, 32'h0, 1'b0);
    drain_ready = 1'b0;
    drive_ld(1'b0, 32'h0, 1'b0);
    test_reset();
    test_sw_drain();
    test_sb();
    test_fill_wrap();
    test_forward();
    test_partial();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/brisc_store_buffer.md
# brisc_store_buffer

Parametrised in-order store buffer between the MEM stage and the data cache. Accepts committed SW/SB stores and retires them to the cache in program order over a valid/ready drain port. A combinational lookup port lets loads forward from pending stores or stall. It succeeds the fixed single-entry store path and generalises depth and width.

## Interface

- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, ADDRESS_BITS (32), store/load address width
- DATA_W, WORLD_LEN (32), word width; byte-enable width is DATA_W/BYTE_LEN

- clk  in  1  clock
- reset_n  in  1  one clock; reset is synchronous and active-low
- push_valid  in  1  MEM stage offers a store
- push_ready  out  1  buffer can accept; = (count < DEPTH)
- push_addr  in  ADDR_W  store byte address
- push_data  in  DATA_W  SW: full word; SB: byte in [7:0]
- push_is_byte  in  1  1 = SB, 0 = SW
- drain_valid  out  1  head entry available; = (count != 0)
- drain_ready  in  1  cache accepts head
- drain_addr  out  ADDR_W  head address, bits [1:0] forced to 0
- drain_data  out  DATA_W  lane-aligned head data
- drain_be  out  DATA_W/8  head byte enables
- ld_addr  in  ADDR_W  load address from MEM stage
- ld_valid  in  1  lookup active
- ld_is_byte  in  1  1 = LB, 0 = LW
- ld_hit  out  1  forwarded data valid
- ld_data  out  DATA_W  forwarded data
- ld_stall  out  1  partial overlap; load must wait
- empty  out  1  count == 0 (fence/exception drain wait)

## Operation

- Circular FIFO: head pointer, tail pointer ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH+1) bits).
- Push (push_valid && push_ready): entry[tail] <= {word addr, data, be}; tail++.
  - SW: data = push_data, be = 4'b1111 (all ones for DATA_W). Misaligned SW (addr[1:0] != 0) is not accepted here; decode raises the exception upstream — buffer stores it word-aligned, undefined data.
  - SB: data = push_data[7:0] replicated to all lanes, be = one-hot at lane addr[1:0].
- Drain (drain_valid && drain_ready): head++. Outputs come straight from entry[head].
- Push and drain in same cycle: both happen, count unchanged. When full, push_ready = 0 even if drain fires that cycle (no ready-through path).
- Lookup (combinational, ld_valid=1): search entries valid this cycle for the youngest with matching word address (addr[ADDR_W-1:2]).
  - No match: ld_hit=0, ld_stall=0.
  - Match, entry be covers all requested bytes (LW: all lanes; LB: lane ld_addr[1:0]): ld_hit=1. LW: ld_data = entry data. LB: ld_data = {zeros, lane byte}; sign extension done in writeback.
  - Match but not covering: ld_hit=0, ld_stall=1; older entries are not merged.
  - ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0.
- Entry being drained this cycle is still searched; entry being pushed this cycle is not.

## Timing

- Reset (reset_n=0 at edge): head=tail=count=0; push_ready=1, drain_valid=0, empty=1, ld_hit=0, ld_stall=0; entry contents not reset.
- Push-to-drain latency: 1 cycle (accepted at edge N, drain_valid high in cycle N+1).
- Push-to-forward latency: 1 cycle.
- drain_addr/data/be stable while drain_valid && !drain_ready.
- Reset mid-operation discards all pending entries; no drain handshake completes in the reset cycle.

## Test plan

- Reset, then SW 0x100 = 0xDEADBEEF, drain_ready=0 -> next cycle drain_valid=1, drain_addr=0x100, drain_data=0xDEADBEEF, drain_be=4'hF; held 3 cycles; drain_ready=1 -> empty=1 next cycle.
- SB 0x203 data 0xA5 -> drain_be=4'b1000, drain_data=0xA5A5A5A5, drain_addr=0x200.
- Fill 4 SWs with drain_ready=0 -> push_ready=0 after 4th; push+drain same cycle when count=3 -> count stays 3; pointers wrap after 8 pushes, order preserved.
- SW 0x300=0x11111111 then SW 0x300=0x22222222, LW 0x300 -> ld_hit=1, ld_data=0x22222222; LB 0x302 -> ld_data=0x00000022.
- SW 0x400=0x12345678 then SB 0x401=0xFF; LW 0x400 -> ld_stall=1, ld_hit=0; LB 0x401 -> ld_hit=1, ld_data=0xFF; LB 0x402 -> ld_stall=1.
- Three pushes pending, reset_n=0 one cycle -> drain_valid=0, empty=1, push_ready=1; LW to pushed address -> ld_hit=0.
